// File: rtl/ps2_keyboard_rx_if.sv
// Event bundle produced by the PS/2 keyboard receiver: decoded scan codes,
// their prefix flags and the frame status seen by downstream logic.
interface ps2_keyboard_rx_if;
  logic [7:0] code;
  logic       code_valid;
  logic       is_break;
  logic       is_extended;
  logic       frame_err;
  logic       busy;

  modport master (
    output code, code_valid, is_break, is_extended, frame_err, busy
  );

  modport slave (
    input  code, code_valid, is_break, is_extended, frame_err, busy
  );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises and de-glitches the raw lines, receives
// 11-bit frames, checks parity/stop/timeout and folds E0/F0 prefixes into flags.
module ps2_keyboard_rx #(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 20000
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  ps2_keyboard_rx_if.master evt
);

  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER);
  // The counter is cleared one cycle after the fall pulse, so it expires one
  // count early to land the error exactly TIMEOUT cycles after that pulse.
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 2);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  logic clk_s1, clk_s2, dat_s1, dat_s2;

  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  logic          clk_filt;
  logic [FW-1:0] filt_cnt;

  // Any sample agreeing with the filtered level restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s2 == clk_filt) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FILT_LAST) begin
      clk_filt <= clk_s2;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + FW'(1);
    end
  end

  logic clk_filt_q;
  logic fall;
  logic bit_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_filt_q <= 1'b1;
      fall       <= 1'b0;
      bit_in     <= 1'b1;
    end else begin
      clk_filt_q <= clk_filt;
      fall       <= clk_filt_q & ~clk_filt;
      bit_in     <= dat_s2;
    end
  end

  state_t        state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          par_bit, par_bit_n;
  logic [TW-1:0] to_cnt, to_cnt_n;
  logic          ext_flag, ext_flag_n;
  logic          brk_flag, brk_flag_n;
  logic [7:0]    code_q, code_n;
  logic          valid_q, valid_n;
  logic          break_q, break_n;
  logic          ext_q, ext_n;
  logic          err_q, err_n;
  logic          busy_q;
  logic          byte_done;
  logic          timed_out;

  assign timed_out = (state != IDLE) && !fall && (to_cnt == TO_LAST);

  // NOTE: every variable gets its default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    par_bit_n  = par_bit;
    ext_flag_n = ext_flag;
    brk_flag_n = brk_flag;
    code_n     = code_q;
    valid_n    = 1'b0;
    break_n    = break_q;
    ext_n      = ext_q;
    err_n      = 1'b0;
    byte_done  = 1'b0;

    if (fall || state == IDLE) to_cnt_n = '0;
    else                       to_cnt_n = to_cnt + TW'(1);

    case (state)
      IDLE: begin
        if (fall && !bit_in) begin
          state_n   = DATA;
          bit_cnt_n = '0;
        end
      end
      DATA: begin
        if (fall) begin
          shreg_n   = {bit_in, shreg[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = PARITY;
        end
      end
      PARITY: begin
        if (fall) begin
          par_bit_n = bit_in;
          state_n   = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          state_n = IDLE;
          if (bit_in && ^{shreg, par_bit}) byte_done = 1'b1;
          else                             err_n     = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (timed_out) begin
      state_n = IDLE;
      err_n   = 1'b1;
    end

    if (err_n) begin
      ext_flag_n = 1'b0;
      brk_flag_n = 1'b0;
    end

    if (byte_done) begin
      case (shreg)
        8'hE0: ext_flag_n = 1'b1;
        8'hF0: brk_flag_n = 1'b1;
        default: begin
          code_n     = shreg;
          break_n    = brk_flag;
          ext_n      = ext_flag;
          valid_n    = 1'b1;
          ext_flag_n = 1'b0;
          brk_flag_n = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      to_cnt   <= '0;
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
      code_q   <= '0;
      valid_q  <= 1'b0;
      break_q  <= 1'b0;
      ext_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      par_bit  <= par_bit_n;
      to_cnt   <= to_cnt_n;
      ext_flag <= ext_flag_n;
      brk_flag <= brk_flag_n;
      code_q   <= code_n;
      valid_q  <= valid_n;
      break_q  <= break_n;
      ext_q    <= ext_n;
      err_q    <= err_n;
      busy_q   <= (state_n != IDLE);
    end
  end

  assign evt.code        = code_q;
  assign evt.code_valid  = valid_q;
  assign evt.is_break    = break_q;
  assign evt.is_extended = ext_q;
  assign evt.frame_err   = err_q;
  assign evt.busy        = busy_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: drives PS/2 frames on the raw lines and scores
// decoded events and frame errors, including their cycle timing, against a
// byte-level model of the prefix/decoder rules.
module tb_ps2_keyboard_rx;
  localparam int FILTER  = 8;
  localparam int TIMEOUT = 600;
  localparam int HALF    = 40;

  typedef struct {
    logic [7:0] code;
    logic       brk;
    logic       ext;
    int         cyc;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  ev_t obs_q[$];
  ev_t exp_q[$];
  int  obs_err_q[$];
  int  exp_err_q[$];
  bit  overlap = 1'b0;
  bit  m_ext = 1'b0;
  bit  m_brk = 1'b0;
  int  last_fall = 0;

  ps2_keyboard_rx_if bus ();

  ps2_keyboard_rx #(.FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .evt      (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.code_valid) obs_q.push_back('{bus.code, bus.is_break, bus.is_extended, cyc});
    if (bus.frame_err) obs_err_q.push_back(cyc);
    if (bus.code_valid && bus.frame_err) overlap = 1'b1;
  end

  // Reference: a good frame's output lands FILTER+5 counted cycles after the
  // negedge where the stop-bit clock was driven low.
  task automatic model_frame(input logic [7:0] b, input bit ok, input int stop_fall);
    if (!ok) begin
      exp_err_q.push_back(stop_fall + FILTER + 5);
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      exp_q.push_back('{b, m_brk, m_ext, stop_fall + FILTER + 5});
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic send_bit(input logic b);
    ps2_data = b;
    repeat (HALF / 2) @(negedge clk);
    last_fall = cyc;
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HALF / 2) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic par;
    par = ~(^b) ^ bad_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(!bad_stop);
    model_frame(b, !bad_par && !bad_stop, last_fall);
    ps2_data = 1'b1;
  endtask

  task automatic test_reset();
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.code !== 8'h00) begin n_errors++; $display("FAIL reset_code: got %h want 00", bus.code); end
    n_checks++; if (bus.code_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", bus.code_valid); end
    n_checks++; if (bus.is_break !== 1'b0) begin n_errors++; $display("FAIL reset_break: got %b want 0", bus.is_break); end
    n_checks++; if (bus.is_extended !== 1'b0) begin n_errors++; $display("FAIL reset_ext: got %b want 0", bus.is_extended); end
    n_checks++; if (bus.frame_err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b want 0", bus.frame_err); end
    n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_make();
    ev_t o, e;
    send_frame(8'h1C, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_errors++; $display("FAIL make_count: got %0d events want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
      if (o.code !== e.code || o.brk !== e.brk || o.ext !== e.ext || o.cyc != e.cyc) begin
        n_errors++;
        $display("FAIL make_event: got code=%h brk=%b ext=%b cyc=%0d want code=%h brk=%b ext=%b cyc=%0d",
                 o.code, o.brk, o.ext, o.cyc, e.code, e.brk, e.ext, e.cyc);
      end
    end
    n_checks++;
    if (obs_err_q.size() != 0) begin n_errors++; $display("FAIL make_err: got %0d frame errors want 0", obs_err_q.size()); end
    obs_q.delete(); exp_q.delete(); obs_err_q.delete(); exp_err_q.delete();
  endtask

  task automatic test_release_ext();
    ev_t o, e;
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    n_checks++;
    if (obs_q.size() != exp_q.size() || obs_err_q.size() != 0) begin
      n_errors++; $display("FAIL release_count: got %0d events %0d errors want %0d events 0 errors",
                           obs_q.size(), obs_err_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
      if (o.code !== e.code || o.brk !== e.brk || o.ext !== e.ext || o.cyc != e.cyc) begin
        n_errors++;
        $display("FAIL release_event: got code=%h brk=%b ext=%b cyc=%0d want code=%h brk=%b ext=%b cyc=%0d",
                 o.code, o.brk, o.ext, o.cyc, e.code, e.brk, e.ext, e.cyc);
      end
    end
    obs_q.delete(); exp_q.delete(); obs_err_q.delete(); exp_err_q.delete();
  endtask

  task automatic test_parity_err();
    ev_t o, e;
    int  oe, ee;
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b1, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    n_checks++;
    if (obs_err_q.size() != exp_err_q.size()) begin
      n_errors++; $display("FAIL parity_err_count: got %0d want %0d", obs_err_q.size(), exp_err_q.size());
    end
    while (obs_err_q.size() > 0 && exp_err_q.size() > 0) begin
      oe = obs_err_q.pop_front(); ee = exp_err_q.pop_front(); n_checks++;
      if (oe != ee) begin n_errors++; $display("FAIL parity_err_time: got cyc %0d want %0d", oe, ee); end
    end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_errors++; $display("FAIL parity_count: got %0d events want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
      if (o.code !== e.code || o.brk !== e.brk || o.ext !== e.ext || o.cyc != e.cyc) begin
        n_errors++;
        $display("FAIL parity_event: got code=%h brk=%b ext=%b cyc=%0d want code=%h brk=%b ext=%b cyc=%0d",
                 o.code, o.brk, o.ext, o.cyc, e.code, e.brk, e.ext, e.cyc);
      end
    end
    obs_q.delete(); exp_q.delete(); obs_err_q.delete(); exp_err_q.delete();
  endtask

  task automatic test_timeout();
    ev_t o, e;
    int  oe, ee;
    send_frame(8'hE0, 1'b0, 1'b0);
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
    n_checks++;
    if (bus.busy !== 1'b1) begin n_errors++; $display("FAIL timeout_busy_mid: got %b want 1", bus.busy); end
    exp_err_q.push_back(last_fall + FILTER + 4 + TIMEOUT);
    m_ext = 1'b0;
    m_brk = 1'b0;
    ps2_data = 1'b1;
    repeat (TIMEOUT + 10) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL timeout_busy_after: got %b want 0", bus.busy); end
    send_frame(8'h1C, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    n_checks++;
    if (obs_err_q.size() != exp_err_q.size()) begin
      n_errors++; $display("FAIL timeout_err_count: got %0d want %0d", obs_err_q.size(), exp_err_q.size());
    end
    while (obs_err_q.size() > 0 && exp_err_q.size() > 0) begin
      oe = obs_err_q.pop_front(); ee = exp_err_q.pop_front(); n_checks++;
      if (oe != ee) begin n_errors++; $display("FAIL timeout_err_time: got cyc %0d want %0d", oe, ee); end
    end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_errors++; $display("FAIL timeout_count: got %0d events want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
      if (o.code !== e.code || o.brk !== e.brk || o.ext !== e.ext || o.cyc != e.cyc) begin
        n_errors++;
        $display("FAIL timeout_event: got code=%h brk=%b ext=%b cyc=%0d want code=%h brk=%b ext=%b cyc=%0d",
                 o.code, o.brk, o.ext, o.cyc, e.code, e.brk, e.ext, e.cyc);
      end
    end
    obs_q.delete(); exp_q.delete(); obs_err_q.delete(); exp_err_q.delete();
  endtask

  task automatic test_glitch();
    bit busy_seen;
    busy_seen = 1'b0;
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (bus.busy) busy_seen = 1'b1;
    end
    n_checks++;
    if (busy_seen !== 1'b0) begin n_errors++; $display("FAIL glitch_busy: got %b want 0", busy_seen); end
    n_checks++;
    if (obs_q.size() != 0 || obs_err_q.size() != 0) begin
      n_errors++; $display("FAIL glitch_outputs: got %0d events %0d errors want 0 0", obs_q.size(), obs_err_q.size());
    end
    obs_q.delete(); obs_err_q.delete();
  endtask

  task automatic test_reset_mid();
    ev_t o, e;
    send_frame(8'hF0, 1'b0, 1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_ext = 1'b0;
    m_brk = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.code, bus.code_valid, bus.is_break, bus.is_extended, bus.frame_err, bus.busy} !== 13'd0) begin
      n_errors++;
      $display("FAIL reset_mid_outputs: got code=%h valid=%b brk=%b ext=%b err=%b busy=%b want all 0",
               bus.code, bus.code_valid, bus.is_break, bus.is_extended, bus.frame_err, bus.busy);
    end
    send_frame(8'h1C, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    n_checks++;
    if (obs_q.size() != exp_q.size() || obs_err_q.size() != 0) begin
      n_errors++; $display("FAIL reset_mid_count: got %0d events %0d errors want %0d events 0 errors",
                           obs_q.size(), obs_err_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
      if (o.code !== e.code || o.brk !== e.brk || o.ext !== e.ext || o.cyc != e.cyc) begin
        n_errors++;
        $display("FAIL reset_mid_event: got code=%h brk=%b ext=%b cyc=%0d want code=%h brk=%b ext=%b cyc=%0d",
                 o.code, o.brk, o.ext, o.cyc, e.code, e.brk, e.ext, e.cyc);
      end
    end
    obs_q.delete(); exp_q.delete(); obs_err_q.delete(); exp_err_q.delete();
  endtask

  task automatic test_random();
    ev_t        o, e;
    int         oe, ee, r, f;
    logic [7:0] b;
    for (int i = 0; i < 24; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 20)      b = 8'hE0;
      else if (r < 40) b = 8'hF0;
      else             b = 8'($urandom);
      f = int'($urandom_range(0, 9));
      send_frame(b, f == 0, f == 1);
      repeat (20) @(negedge clk);
    end
    n_checks++;
    if (obs_err_q.size() != exp_err_q.size()) begin
      n_errors++; $display("FAIL random_err_count: got %0d want %0d", obs_err_q.size(), exp_err_q.size());
    end
    while (obs_err_q.size() > 0 && exp_err_q.size() > 0) begin
      oe = obs_err_q.pop_front(); ee = exp_err_q.pop_front(); n_checks++;
      if (oe != ee) begin n_errors++; $display("FAIL random_err_time: got cyc %0d want %0d", oe, ee); end
    end
    n_checks++;
    if (obs_q.size() != exp_q.size()) begin
      n_errors++; $display("FAIL random_count: got %0d events want %0d", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front(); n_checks++;
      if (o.code !== e.code || o.brk !== e.brk || o.ext !== e.ext || o.cyc != e.cyc) begin
        n_errors++;
        $display("FAIL random_event: got code=%h brk=%b ext=%b cyc=%0d want code=%h brk=%b ext=%b cyc=%0d",
                 o.code, o.brk, o.ext, o.cyc, e.code, e.brk, e.ext, e.cyc);
      end
    end
    n_checks++;
    if (overlap !== 1'b0) begin n_errors++; $display("FAIL valid_err_overlap: got %b want 0", overlap); end
    obs_q.delete(); exp_q.delete(); obs_err_q.delete(); exp_err_q.delete();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_make();
    test_release_ext();
    test_parity_err();
    test_timeout();
    test_glitch();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
